// File: rtl/scope_frame_decoder.sv
// Receive-side decoder for the 8-phase scope stream.
// Locks on the long 0xFF sync run and tracks the last position of each object.
module scope_frame_decoder #(
  parameter int PHASE_BITS = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] scope_in,
  output logic       obj_valid,
  output logic [2:0] obj_index,
  output logic [6:0] obj_x,
  output logic [5:0] obj_y,
  output logic       locked,
  output logic       sync_err,
  input  logic [2:0] rd_addr,
  output logic [6:0] rd_x,
  output logic [5:0] rd_y,
  output logic       rd_seen
);

  localparam int P  = PHASE_BITS;
  localparam int FW = PHASE_BITS + 3;

  localparam logic [FW-1:0] RUN_MIN  = FW'(2) << P;
  localparam logic [FW-1:0] RUN_MAX  = FW'(5) << P;
  localparam logic [FW-1:0] RUN_SAT  = '1;
  localparam logic [FW-1:0] CNT_LOAD = (FW'(6) << P) | FW'(1);
  localparam logic [P-1:0]  SAMPLE   = P'(1) << (P - 1);

  localparam logic S_SEARCH = 1'b0;
  localparam logic S_TRACK  = 1'b1;

  logic [7:0]    din_q;
  logic          state_q, state_d;
  logic [FW-1:0] ff_run_q, ff_run_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          idx_ok_q, idx_ok_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    y_q, y_d;
  logic          obj_valid_q, obj_valid_d;
  logic [2:0]    obj_index_q, obj_index_d;
  logic [6:0]    obj_x_q, obj_x_d;
  logic [5:0]    obj_y_q, obj_y_d;
  logic          locked_q, locked_d;
  logic          sync_err_q, sync_err_d;
  logic [6:0]    tbl_x_q [8];
  logic [6:0]    tbl_x_d [8];
  logic [5:0]    tbl_y_q [8];
  logic [5:0]    tbl_y_d [8];
  logic [7:0]    tbl_seen_q, tbl_seen_d;

  logic       din_ff;
  logic       at_sample;
  logic       chk_ok;
  logic [2:0] phase;

  always_comb begin
    din_ff      = (din_q == 8'hFF);
    phase       = frame_cnt_q[P+2:P];
    at_sample   = (frame_cnt_q[P-1:0] == SAMPLE);
    chk_ok      = 1'b1;
    state_d     = state_q;
    ff_run_d    = ff_run_q;
    frame_cnt_d = frame_cnt_q;
    idx_ok_d    = idx_ok_q;
    idx_d       = idx_q;
    y_d         = y_q;
    obj_valid_d = 1'b0;
    obj_index_d = obj_index_q;
    obj_x_d     = obj_x_q;
    obj_y_d     = obj_y_q;
    locked_d    = locked_q;
    sync_err_d  = 1'b0;
    tbl_x_d     = tbl_x_q;
    tbl_y_d     = tbl_y_q;
    tbl_seen_d  = tbl_seen_q;

    if (obj_valid_q) begin
      tbl_x_d[obj_index_q]    = obj_x_q;
      tbl_y_d[obj_index_q]    = obj_y_q;
      tbl_seen_d[obj_index_q] = 1'b1;
    end

    case (state_q)
      S_SEARCH: begin
        if (din_ff) begin
          if (ff_run_q != RUN_SAT) ff_run_d = ff_run_q + FW'(1);
        end else begin
          ff_run_d = '0;
          // end of the 4-phase sync run: this cycle is phase 6, offset 0
          if (ff_run_q >= RUN_MIN && ff_run_q <= RUN_MAX) begin
            frame_cnt_d = CNT_LOAD;
            idx_ok_d    = 1'b0;
            state_d     = S_TRACK;
          end
        end
      end
      default: begin
        frame_cnt_d = frame_cnt_q + FW'(1);
        if (at_sample) begin
          case (phase)
            3'd1: begin
              chk_ok   = (din_q <= 8'd7);
              idx_d    = din_q[2:0];
              idx_ok_d = 1'b1;
            end
            3'd6: begin
              chk_ok = (din_q <= 8'd63);
              y_d    = din_q[5:0];
            end
            3'd7: begin
              chk_ok = (din_q <= 8'd127);
              if (chk_ok && idx_ok_q) begin
                obj_valid_d = 1'b1;
                obj_index_d = idx_q;
                obj_x_d     = din_q[6:0];
                obj_y_d     = y_q;
                locked_d    = 1'b1;
              end
            end
            default: chk_ok = din_ff;
          endcase
          if (!chk_ok) begin
            sync_err_d = 1'b1;
            locked_d   = 1'b0;
            idx_ok_d   = 1'b0;
            ff_run_d   = '0;
            state_d    = S_SEARCH;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      din_q       <= '0;
      state_q     <= S_SEARCH;
      ff_run_q    <= '0;
      frame_cnt_q <= '0;
      idx_ok_q    <= 1'b0;
      idx_q       <= '0;
      y_q         <= '0;
      obj_valid_q <= 1'b0;
      obj_index_q <= '0;
      obj_x_q     <= '0;
      obj_y_q     <= '0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      tbl_x_q     <= '{default: '0};
      tbl_y_q     <= '{default: '0};
      tbl_seen_q  <= '0;
    end else begin
      din_q       <= scope_in;
      state_q     <= state_d;
      ff_run_q    <= ff_run_d;
      frame_cnt_q <= frame_cnt_d;
      idx_ok_q    <= idx_ok_d;
      idx_q       <= idx_d;
      y_q         <= y_d;
      obj_valid_q <= obj_valid_d;
      obj_index_q <= obj_index_d;
      obj_x_q     <= obj_x_d;
      obj_y_q     <= obj_y_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
      tbl_x_q     <= tbl_x_d;
      tbl_y_q     <= tbl_y_d;
      tbl_seen_q  <= tbl_seen_d;
    end
  end

  assign obj_valid = obj_valid_q;
  assign obj_index = obj_index_q;
  assign obj_x     = obj_x_q;
  assign obj_y     = obj_y_q;
  assign locked    = locked_q;
  assign sync_err  = sync_err_q;
  assign rd_x      = tbl_x_q[rd_addr];
  assign rd_y      = tbl_y_q[rd_addr];
  assign rd_seen   = tbl_seen_q[rd_addr];

endmodule

// File: tb/tb_scope_frame_decoder.sv
// Scoreboard bench for scope_frame_decoder with 8-cycle phases.
// Expected records are queued by the stimulus and checked by a monitor.
module tb_scope_frame_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] scope_in;
  logic       obj_valid;
  logic [2:0] obj_index;
  logic [6:0] obj_x;
  logic [5:0] obj_y;
  logic       locked;
  logic       sync_err;
  logic [2:0] rd_addr;
  logic [6:0] rd_x;
  logic [5:0] rd_y;
  logic       rd_seen;

  scope_frame_decoder #(.PHASE_BITS(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .scope_in (scope_in),
    .obj_valid(obj_valid),
    .obj_index(obj_index),
    .obj_x    (obj_x),
    .obj_y    (obj_y),
    .locked   (locked),
    .sync_err (sync_err),
    .rd_addr  (rd_addr),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_seen  (rd_seen)
  );

  always #5 clock = ~clock;

  typedef struct {
    int idx;
    int x;
    int y;
    int gap;
  } rec_t;

  rec_t exp_q[$];
  int   exp_serr = 0;
  int   n_vec = 0;
  int   n_mis = 0;
  logic hold_addr = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor with table model ----------------
  logic rst_seen = 1'b0;
  always @(posedge clock) rst_seen = reset;

  int   m_x [8];
  int   m_y [8];
  int   m_s [8];
  int   cyc = 0;
  int   last_v = -1;
  logic pend = 1'b0;
  rec_t pend_r;

  always @(negedge clock) begin
    rec_t r;
    cyc++;
    if (pend) begin
      m_x[pend_r.idx] = pend_r.x;
      m_y[pend_r.idx] = pend_r.y;
      m_s[pend_r.idx] = 1;
      pend = 1'b0;
    end
    if (rst_seen) begin
      for (int i = 0; i < 8; i++) begin
        m_x[i] = 0; m_y[i] = 0; m_s[i] = 0;
      end
      last_v = -1;
    end
    chk("rd_x", int'(rd_x), m_x[rd_addr]);
    chk("rd_y", int'(rd_y), m_y[rd_addr]);
    chk("rd_seen", int'(rd_seen), m_s[rd_addr]);
    if (obj_valid && sync_err)
      chk("valid_and_err", 1, 0);
    if (obj_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_obj_valid", int'(obj_index), -1);
      end else begin
        r = exp_q.pop_front();
        chk("obj_index", int'(obj_index), r.idx);
        chk("obj_x", int'(obj_x), r.x);
        chk("obj_y", int'(obj_y), r.y);
        chk("locked_at_valid", int'(locked), 1);
        if (r.gap != 0)
          chk("valid_spacing", cyc - last_v, r.gap);
        pend_r = r;
        pend   = 1'b1;
      end
      last_v = cyc;
    end
    if (sync_err) begin
      if (exp_serr > 0) begin
        exp_serr--;
        chk("sync_err", 1, 1 - 0);
      end else begin
        chk("unexpected_sync_err", 1, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      scope_in = v;
      if (!hold_addr) rd_addr = rd_addr + 3'd1;
    end
  endtask

  task automatic send_frame(input int idx, input int y, input int x,
                            input int bad_ph);
    logic [7:0] v;
    for (int ph = 0; ph < 8; ph++) begin
      case (ph)
        1:       v = 8'(idx);
        6:       v = 8'(y);
        7:       v = 8'(x);
        default: v = 8'hFF;
      endcase
      if (ph == bad_ph) v = 8'h00;
      drive(v, 8);
    end
  endtask

  task automatic push(input int idx, input int x, input int y, input int gap);
    rec_t r;
    r.idx = idx; r.x = x; r.y = y; r.gap = gap;
    exp_q.push_back(r);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    scope_in = 8'h00;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_outs_reset(input string tag);
    chk({tag, "_obj_valid"}, int'(obj_valid), 0);
    chk({tag, "_sync_err"}, int'(sync_err), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_obj_index"}, int'(obj_index), 0);
    chk({tag, "_obj_x"}, int'(obj_x), 0);
    chk({tag, "_obj_y"}, int'(obj_y), 0);
  endtask

  initial begin
    int runs [2];
    reset    = 1'b1;
    scope_in = 8'h00;
    rd_addr  = 3'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_outs_reset("reset");
    drive(8'h00, 5);

    // first frame is partial after lock, so only idx 3 is reported
    push(3, 20, 10, 0);
    send_frame(2, 20, 10, -1);
    chk("locked_after_partial", int'(locked), 0);
    send_frame(3, 10, 20, -1);
    chk("locked_after_first", int'(locked), 1);

    for (int i = 0; i < 8; i++) begin
      push(i, 10 + 13 * i, 5 + 7 * i, 64);
      send_frame(i, 5 + 7 * i, 10 + 13 * i, -1);
    end
    chk("locked_after_eight", int'(locked), 1);

    // phase 3 corrupted: error, relock on phase 6, record next frame
    exp_serr++;
    send_frame(5, 33, 44, 3);
    chk("locked_after_err", int'(locked), 0);
    chk("serr_consumed", exp_serr, 0);
    push(6, 30, 40, 0);
    send_frame(6, 40, 30, -1);
    chk("locked_relock", int'(locked), 1);

    // reset in phase 6 of a locked frame
    drive(8'hFF, 8);
    drive(8'h01, 8);
    drive(8'hFF, 32);
    drive(8'd8, 3);
    do_reset();
    chk_outs_reset("midreset");
    hold_addr = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      chk("midreset_rd_seen", int'(rd_seen), 0);
      chk("midreset_rd_x", int'(rd_x), 0);
    end
    hold_addr = 1'b0;
    drive(8'h00, 8);

    // relock, then collide a write to entry 4 with a read of entry 4
    hold_addr = 1'b1;
    rd_addr = 3'd4;
    send_frame(4, 22, 11, -1);
    push(4, 11, 22, 0);
    send_frame(4, 22, 11, -1);
    push(4, 50, 50, 64);
    send_frame(4, 50, 50, -1);
    drive(8'h00, 2);
    chk("coll_rd_x", int'(rd_x), 50);
    chk("coll_rd_y", int'(rd_y), 50);
    hold_addr = 1'b0;

    // overlong sync runs are rejected
    runs[0] = 60;
    runs[1] = 41;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      drive(8'h00, 4);
      drive(8'hFF, runs[k]);
      drive(8'h05, 20);
      drive(8'h00, 20);
      chk("long_run_locked", int'(locked), 0);
    end

    // run of exactly 5 phases is accepted; missing phase-0 sync then errors
    do_reset();
    drive(8'h00, 4);
    exp_serr++;
    drive(8'hFF, 40);
    drive(8'h05, 16);
    drive(8'h00, 16);
    chk("edge_run_serr", exp_serr, 0);
    chk("edge_run_locked", int'(locked), 0);

    drive(8'h00, 5);
    chk("records_left", exp_q.size(), 0);
    chk("serr_left", exp_serr, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
